// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: single-cycle ALU plus iterative 1-bit-per-cycle shifter
module exe_stage (
    input  logic          clk,
    input  logic          resetn,
    input  logic          EXE_valid,
    input  logic [149:0]  ID_EXE_bus_r,
    output logic          EXE_over,
    output logic [105:0]  EXE_MEM_bus,
    output logic [31:0]   EXE_pc
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_t;

    state_t       state_q, state_d;
    shop_t        shop_q, shop_d;
    logic [3:0]   mem_ctl_q, mem_ctl_d;
    logic [31:0]  store_q, store_d;
    logic         rf_wen_q, rf_wen_d;
    logic [4:0]   rf_wdest_q, rf_wdest_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  result_q, result_d;
    logic [31:0]  shreg_q, shreg_d;
    logic [4:0]   cnt_q, cnt_d;

    logic [11:0]  ctl;
    logic [31:0]  op1, op2;
    logic [4:0]   amt;
    assign ctl = ID_EXE_bus_r[149:138];
    assign op1 = ID_EXE_bus_r[137:106];
    assign op2 = ID_EXE_bus_r[105:74];
    assign amt = op1[4:0];

    // Priority decode, add first. Shift ops yield op2 here, which is the
    // correct answer only for amt=0; nonzero amounts go through SHIFT.
    logic [31:0]  alu_res;
    logic         is_shift;
    shop_t        shop_new;
    always_comb begin
        alu_res  = 32'h0;
        is_shift = 1'b0;
        shop_new = SH_LL;
        if (ctl[11])      alu_res = op1 + op2;
        else if (ctl[10]) alu_res = op1 - op2;
        else if (ctl[9])  alu_res = {31'b0, $signed(op1) < $signed(op2)};
        else if (ctl[8])  alu_res = {31'b0, op1 < op2};
        else if (ctl[7])  alu_res = op1 & op2;
        else if (ctl[6])  alu_res = ~(op1 | op2);
        else if (ctl[5])  alu_res = op1 | op2;
        else if (ctl[4])  alu_res = op1 ^ op2;
        else if (ctl[3]) begin alu_res = op2; is_shift = 1'b1; shop_new = SH_LL; end
        else if (ctl[2]) begin alu_res = op2; is_shift = 1'b1; shop_new = SH_RL; end
        else if (ctl[1]) begin alu_res = op2; is_shift = 1'b1; shop_new = SH_RA; end
        else if (ctl[0])  alu_res = {op2[15:0], 16'h0};
    end

    logic [31:0] shifted;
    always_comb begin
        case (shop_q)
            SH_LL:   shifted = {shreg_q[30:0], 1'b0};
            SH_RL:   shifted = {1'b0, shreg_q[31:1]};
            default: shifted = {shreg_q[31], shreg_q[31:1]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shop_d     = shop_q;
        mem_ctl_d  = mem_ctl_q;
        store_d    = store_q;
        rf_wen_d   = rf_wen_q;
        rf_wdest_d = rf_wdest_q;
        pc_d       = pc_q;
        result_d   = result_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (EXE_valid) begin
                    mem_ctl_d  = ID_EXE_bus_r[73:70];
                    store_d    = ID_EXE_bus_r[69:38];
                    rf_wen_d   = ID_EXE_bus_r[37];
                    rf_wdest_d = ID_EXE_bus_r[36:32];
                    pc_d       = ID_EXE_bus_r[31:0];
                    if (is_shift && amt != 5'd0) begin
                        shreg_d = op2;
                        cnt_d   = amt;
                        shop_d  = shop_new;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shifted;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shop_q     <= SH_LL;
            mem_ctl_q  <= 4'h0;
            store_q    <= 32'h0;
            rf_wen_q   <= 1'b0;
            rf_wdest_q <= 5'h0;
            pc_q       <= 32'h0;
            result_q   <= 32'h0;
            shreg_q    <= 32'h0;
            cnt_q      <= 5'h0;
        end else begin
            state_q    <= state_d;
            shop_q     <= shop_d;
            mem_ctl_q  <= mem_ctl_d;
            store_q    <= store_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdest_q <= rf_wdest_d;
            pc_q       <= pc_d;
            result_q   <= result_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign EXE_over    = (state_q == DONE);
    assign EXE_MEM_bus = {mem_ctl_q, store_q, result_q, rf_wen_q, rf_wdest_q, pc_q};
    assign EXE_pc      = pc_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage with directed vectors
module tb_exe_stage;

    logic          clk = 1'b0;
    logic          resetn;
    logic          EXE_valid;
    logic [149:0]  ID_EXE_bus_r;
    logic          EXE_over;
    logic [105:0]  EXE_MEM_bus;
    logic [31:0]   EXE_pc;

    exe_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_valid    (EXE_valid),
        .ID_EXE_bus_r (ID_EXE_bus_r),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .EXE_pc       (EXE_pc)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] C_ADD = 12'h800, C_SUB = 12'h400, C_SLT = 12'h200, C_SLTU = 12'h100,
                            C_AND = 12'h080, C_NOR = 12'h040, C_OR  = 12'h020, C_XOR  = 12'h010,
                            C_SLL = 12'h008, C_SRL = 12'h004, C_SRA = 12'h002, C_LUI  = 12'h001;

    typedef struct {
        logic [105:0] bus;
        logic [31:0]  pc;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [105:0] last_bus;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every EXE_over pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && EXE_over === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_over: cycle %0d bus=%h, required no EXE_over", cyc, EXE_MEM_bus);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (EXE_MEM_bus !== e.bus || EXE_pc !== e.pc || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL over_check: bus=%h pc=%h cycle=%0d, required bus=%h pc=%h cycle=%0d",
                             EXE_MEM_bus, EXE_pc, cyc, e.bus, e.pc, e.cyc);
                end
            end
        end
    end

    function automatic logic [149:0] mk_bus(input logic [11:0] ctl, input logic [31:0] op1,
                                            input logic [31:0] op2, input logic [3:0] mc,
                                            input logic [31:0] sd, input logic wen,
                                            input logic [4:0] wd, input logic [31:0] pc);
        return {ctl, op1, op2, mc, sd, wen, wd, pc};
    endfunction

    task automatic expect_out(input logic [149:0] b, input logic [31:0] res, input int cyc_at);
        exp_t e;
        e.bus = {b[73:70], b[69:38], res, b[37], b[36:32], b[31:0]};
        e.pc  = b[31:0];
        e.cyc = cyc_at;
        sb.push_back(e);
        last_bus = e.bus;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end else begin
            @(posedge clk); #1;
            if (EXE_MEM_bus !== last_bus) begin
                n_err++;
                $display("FAIL %s_hold: bus=%h, required %h", name, EXE_MEM_bus, last_bus);
            end
        end
    endtask

    // One instruction; the ID bus is scrambled right after capture so the
    // in-flight operation must not depend on it.
    task automatic issue(input string name, input logic [11:0] ctl, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [3:0] mc, input logic [31:0] sd,
                         input logic wen, input logic [4:0] wd, input logic [31:0] pc,
                         input logic [31:0] res, input int lat);
        logic [149:0] b;
        b = mk_bus(ctl, op1, op2, mc, sd, wen, wd, pc);
        ID_EXE_bus_r = b;
        EXE_valid    = 1'b1;
        expect_out(b, res, cyc + lat);
        @(posedge clk); #1;
        EXE_valid    = 1'b0;
        ID_EXE_bus_r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drain(name);
    endtask

    initial begin
        logic [149:0] b1, b2;
        resetn       = 1'b0;
        EXE_valid    = 1'b0;
        ID_EXE_bus_r = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (EXE_over !== 1'b0 || EXE_MEM_bus !== 106'h0 || EXE_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_init: over=%b bus=%h pc=%h, required 0/0/0", EXE_over, EXE_MEM_bus, EXE_pc);
        end
        resetn = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of sll by 20: aborted, no pulse afterwards.
        ID_EXE_bus_r = mk_bus(C_SLL, 32'd20, 32'h1, 4'h3, 32'hDEAD_BEEF, 1'b1, 5'd9, 32'h1000_0000);
        EXE_valid    = 1'b1;
        @(posedge clk); #1;
        EXE_valid    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (EXE_over !== 1'b0 || EXE_MEM_bus !== 106'h0 || EXE_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_shift: over=%b bus=%h pc=%h, required 0/0/0", EXE_over, EXE_MEM_bus, EXE_pc);
        end
        resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        issue("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0, 1'b1, 5'd5, 32'hBFC0_0010, 32'h0, 1);
        issue("slt",  C_SLT,  32'h8000_0000, 32'h1, 4'h1, 32'h11, 1'b1, 5'd6, 32'hBFC0_0014, 32'h1, 1);
        issue("sltu", C_SLTU, 32'h8000_0000, 32'h1, 4'h2, 32'h22, 1'b1, 5'd7, 32'hBFC0_0018, 32'h0, 1);
        issue("sra31", C_SRA, 32'd31, 32'h8000_0000, 4'h5, 32'hCAFE_F00D, 1'b1, 5'd8, 32'hBFC0_001C, 32'hFFFF_FFFF, 32);
        issue("srl31", C_SRL, 32'd31, 32'h8000_0000, 4'hA, 32'h0BAD_F00D, 1'b0, 5'd9, 32'hBFC0_0020, 32'h1, 32);
        issue("sll0", C_SLL, 32'hFFFF_FFE0, 32'h1234_5678, 4'h0, 32'h0, 1'b1, 5'd10, 32'hBFC0_0024, 32'h1234_5678, 1);
        issue("lui",  C_LUI, 32'h0, 32'h0000_ABCD, 4'h0, 32'h0, 1'b1, 5'd11, 32'hBFC0_0028, 32'hABCD_0000, 1);
        issue("sub",  C_SUB, 32'd5, 32'd7, 4'h0, 32'h0, 1'b1, 5'd12, 32'hBFC0_002C, 32'hFFFF_FFFE, 1);
        issue("and",  C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 32'h0, 1'b1, 5'd13, 32'h30, 32'hF000_F000, 1);
        issue("or",   C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 32'h0, 1'b1, 5'd14, 32'h34, 32'hFFF0_FFF0, 1);
        issue("xor",  C_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 32'h0, 1'b1, 5'd15, 32'h38, 32'h0FF0_0FF0, 1);
        issue("nor",  C_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 32'h0, 1'b1, 5'd16, 32'h3C, 32'h000F_000F, 1);
        issue("no_op", 12'h000, 32'h1234, 32'h5678, 4'h0, 32'h0, 1'b0, 5'd0, 32'h40, 32'h0, 1);
        issue("prio", C_ADD | C_SLL, 32'd3, 32'd4, 4'h0, 32'h0, 1'b1, 5'd17, 32'h44, 32'd7, 1);
        issue("sll4", C_SLL, 32'hFFFF_FFE4, 32'h0000_00F1, 4'h6, 32'h5555_AAAA, 1'b1, 5'd18, 32'h48, 32'h0000_0F10, 5);
        issue("sra1", C_SRA, 32'd1, 32'h8000_0001, 4'h9, 32'h1357_9BDF, 1'b1, 5'd19, 32'h4C, 32'hC000_0000, 2);

        // Back-to-back: EXE_valid held high through EXE_over; the second
        // capture happens only in the IDLE cycle after DONE.
        b1 = mk_bus(C_ADD, 32'd100, 32'd23, 4'h1, 32'hAAAA_0001, 1'b1, 5'd20, 32'h100);
        b2 = mk_bus(C_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h2, 32'hBBBB_0002, 1'b1, 5'd21, 32'h104);
        ID_EXE_bus_r = b1;
        EXE_valid    = 1'b1;
        expect_out(b1, 32'd123, cyc + 1);
        @(posedge clk); #1;
        ID_EXE_bus_r = b2;
        expect_out(b2, 32'hF0F0_0F0F, cyc + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        EXE_valid = 1'b0;
        drain("back2back");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the multi-cycle CPU, directly downstream of the decode stage.
- Captures the 150-bit ID->EXE bus and computes the ALU result.
- Non-shift ops complete in one cycle; shifts use an area-saving iterative 1-bit-per-cycle shifter.
- Produces the EXE->MEM bus and a one-cycle EXE_over pulse for the top-level stage controller.

Parameters:
- none (widths fixed by the ID->EXE and EXE->MEM bus formats)

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- EXE_valid  in  1  level; stage active, instruction present on ID_EXE_bus_r
- ID_EXE_bus_r  in  150  {alu_control[149:138], alu_operand1[137:106], alu_operand2[105:74], mem_control[73:70], store_data[69:38], rf_wen[37], rf_wdest[36:32], pc[31:0]}
- EXE_over  out  1  one-cycle pulse, result valid
- EXE_MEM_bus  out  106  {mem_control[105:102], store_data[101:70], exe_result[69:38], rf_wen[37], rf_wdest[36:32], pc[31:0]}
- EXE_pc  out  32  pc of captured instruction, for display

Behaviour:
- Reset: when resetn=0 at a clock edge:
  - state=IDLE, EXE_over=0
  - all captured fields, result, shift register and count cleared, so EXE_MEM_bus=0 and EXE_pc=0
  - Reset aborts any in-progress shift; no EXE_over is produced for the aborted instruction.
- alu_control bit order, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Exactly one bit is expected set. If none is set, exe_result=0.
  - If several are set, the MSB-first priority applies.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If EXE_valid=1: capture mem_control, store_data, rf_wen, rf_wdest and pc.
  - Shift op with amt=alu_operand1[4:0] nonzero: shreg<=alu_operand2, cnt<=amt, go to SHIFT.
  - Otherwise: exe_result<=ALU(op1,op2), go to DONE.
  - If EXE_valid=0: hold state and outputs.
- ALU rules (32-bit, results modulo 2^32, no overflow trap):
  - add = op1+op2; sub = op1-op2
  - slt = signed(op1)<signed(op2) ? 1 : 0; sltu = unsigned compare, result {31'b0,flag}
  - and, or, xor, nor = bitwise
  - lui = {op2[15:0],16'h0}
  - shifts act on op2 by op1[4:0]; op1[31:5] ignored
- SHIFT state, each cycle:
  - sll shifts shreg left by 1, zero fill; srl shifts right by 1, zero fill; sra shifts right by 1, replicating bit31.
  - cnt decrements by 1.
  - When cnt==1 the final shifted value is written to exe_result and the state goes to DONE.
  - EXE_valid is ignored while in SHIFT.
- Shift with amt=0: result = op2, handled in IDLE as a non-shift op (latency 1).
- DONE: EXE_over=1 for exactly this cycle; next state is IDLE.
- Latency, capture edge to EXE_over high:
  - 1 cycle for non-shift ops and zero-amount shifts
  - amt+1 cycles for shifts; 32 cycles maximum (amt=31)
- Handshake with the top-level controller:
  - It must deassert EXE_valid in the cycle EXE_over is high.
  - If EXE_valid is still 1 in the following IDLE cycle, that is a new instruction and the bus is recaptured.
- Output hold: EXE_MEM_bus and EXE_pc are registered. They hold their value from DONE until the next capture, so MEM may sample them any time after EXE_over.
- EXE_MEM_bus fields are direct copies of the captured ID bus fields, except exe_result.
- A change on ID_EXE_bus_r after capture does not affect the in-flight operation.

Test Plan:
- Reset: hold resetn=0 for 2 cycles mid-SHIFT (sll by 20) -> state IDLE, EXE_over never pulses, EXE_MEM_bus=0, EXE_pc=0.
- add with op1=32'hFFFF_FFFF, op2=1, rf_wen=1, rf_wdest=5, pc=32'hBFC0_0010 -> one cycle later:
  - EXE_over=1, exe_result=0, bus[37:32]={1,5'd5}, EXE_pc=32'hBFC0_0010.
- slt vs sltu with op1=32'h8000_0000, op2=1 -> slt result 1, sltu result 0, each with 1-cycle latency.
- sra with op1=31, op2=32'h8000_0000 -> EXE_over exactly 32 cycles after capture, result 32'hFFFF_FFFF. srl with the same operands -> 1.
- sll with amt=0, op2=32'h1234_5678 -> latency 1, result 32'h1234_5678. lui with op2=32'h0000_ABCD -> 32'hABCD_0000.
- Back-to-back handshake: EXE_valid held high through EXE_over -> second capture in the next IDLE cycle. ID bus changed during SHIFT -> in-flight result unaffected; store_data and mem_control passed through unchanged.
